// File: rtl/os_cmd_collector.sv
// Collects a command (user, action, item, quantity, seller, amount) from a stream of
// single-field valid strobes sharing the D bus, then presents it with a valid/ready handshake.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_valid            D[7:0] is a user ID (in IDLE) or a seller ID (W_SELLER / W_CHK)
//   act_valid           D[3:0] is an action: 1 Buy, 2 Check, 4 Deposit, 8 Return
//   item_valid          D[1:0] is an item ID
//   num_valid           D[5:0] is an item count
//   amnt_valid          D[15:0] is a money amount
//   cmd_ready           downstream accepts the pending command
//   cmd_*               registered command fields, valid while cmd_valid is high
//   proto_err           registered one-cycle pulse per protocol violation
module os_cmd_collector (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        act_valid,
  input  logic        item_valid,
  input  logic        num_valid,
  input  logic        amnt_valid,
  input  logic [15:0] D,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [7:0]  cmd_user,
  output logic        cmd_user_new,
  output logic [3:0]  cmd_act,
  output logic [1:0]  cmd_item,
  output logic [5:0]  cmd_num,
  output logic [7:0]  cmd_seller,
  output logic [15:0] cmd_amnt,
  output logic        cmd_chk_seller,
  output logic        proto_err
);

  localparam logic [3:0] ActBuy     = 4'd1;
  localparam logic [3:0] ActCheck   = 4'd2;
  localparam logic [3:0] ActDeposit = 4'd4;
  localparam logic [3:0] ActReturn  = 4'd8;

  // Last W_CHK cycle (T+5) has window count 4.
  localparam logic [2:0] ChkLast = 3'd4;

  typedef enum logic [2:0] {
    StIdle, StGotUser, StWItem, StWNum, StWSeller, StWAmnt, StWChk, StIssue
  } state_e;

  state_e      state_q, state_d, act_next;
  logic        logged_q, logged_d;
  logic [2:0]  win_q, win_d;
  logic [7:0]  user_q, user_d;
  logic        user_new_q, user_new_d;
  logic [3:0]  act_q, act_d;
  logic [1:0]  item_q, item_d;
  logic [5:0]  num_q, num_d;
  logic [7:0]  seller_q, seller_d;
  logic [15:0] amnt_q, amnt_d;
  logic        chk_q, chk_d;
  logic        valid_q, valid_d;
  logic        perr_q, perr_d;

  logic [2:0]  n_valid;
  logic        any_valid, multi_valid, act_ok;

  assign n_valid = {2'b0, id_valid} + {2'b0, act_valid} + {2'b0, item_valid} +
                   {2'b0, num_valid} + {2'b0, amnt_valid};
  assign any_valid   = (n_valid != 3'd0);
  assign multi_valid = (n_valid > 3'd1);

  // Decode the action on D into its wait state.
  always_comb begin
    act_next = StIdle;
    act_ok   = 1'b1;
    case (D[3:0])
      ActBuy, ActReturn: act_next = StWItem;
      ActDeposit:        act_next = StWAmnt;
      ActCheck:          act_next = StWChk;
      default:           act_ok   = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    logged_d   = logged_q;
    win_d      = win_q;
    user_d     = user_q;
    user_new_d = user_new_q;
    act_d      = act_q;
    item_d     = item_q;
    num_d      = num_q;
    seller_d   = seller_q;
    amnt_d     = amnt_q;
    chk_d      = chk_q;
    valid_d    = valid_q;
    perr_d     = 1'b0;

    if (state_q == StIssue) begin
      // Pending command is frozen; stray strobes only flag an error.
      if (any_valid) perr_d = 1'b1;
      if (cmd_ready) begin
        state_d    = StIdle;
        valid_d    = 1'b0;
        user_new_d = 1'b0;
      end
    end else if (multi_valid) begin
      perr_d  = 1'b1;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StGotUser: begin
          if (id_valid) begin
            user_d     = D[7:0];
            logged_d   = 1'b1;
            user_new_d = 1'b1;
            state_d    = StGotUser;
          end else if (act_valid) begin
            if (logged_q && act_ok) begin
              // Unused fields of this action must read as zero at issue time.
              act_d    = D[3:0];
              item_d   = '0;
              num_d    = '0;
              seller_d = '0;
              amnt_d   = '0;
              chk_d    = 1'b0;
              win_d    = '0;
              state_d  = act_next;
            end else begin
              perr_d  = 1'b1;
              state_d = StIdle;
            end
          end else if (any_valid) begin
            perr_d  = 1'b1;
            state_d = StIdle;
          end
        end
        StWItem: begin
          if (item_valid) begin
            item_d  = D[1:0];
            state_d = StWNum;
          end else if (any_valid) begin
            perr_d  = 1'b1;
            state_d = StIdle;
          end
        end
        StWNum: begin
          if (num_valid) begin
            num_d   = D[5:0];
            state_d = StWSeller;
          end else if (any_valid) begin
            perr_d  = 1'b1;
            state_d = StIdle;
          end
        end
        StWSeller: begin
          if (id_valid) begin
            seller_d = D[7:0];
            valid_d  = 1'b1;
            state_d  = StIssue;
          end else if (any_valid) begin
            perr_d  = 1'b1;
            state_d = StIdle;
          end
        end
        StWAmnt: begin
          if (amnt_valid) begin
            amnt_d  = D;
            valid_d = 1'b1;
            state_d = StIssue;
          end else if (any_valid) begin
            perr_d  = 1'b1;
            state_d = StIdle;
          end
        end
        StWChk: begin
          if (id_valid) begin
            seller_d = D[7:0];
            chk_d    = 1'b1;
            valid_d  = 1'b1;
            state_d  = StIssue;
          end else if (any_valid) begin
            perr_d  = 1'b1;
            state_d = StIdle;
          end else if (win_q == ChkLast) begin
            valid_d = 1'b1;
            state_d = StIssue;
          end else begin
            win_d = win_q + 3'd1;
          end
        end
        StIssue: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      logged_q   <= 1'b0;
      win_q      <= '0;
      user_q     <= '0;
      user_new_q <= 1'b0;
      act_q      <= '0;
      item_q     <= '0;
      num_q      <= '0;
      seller_q   <= '0;
      amnt_q     <= '0;
      chk_q      <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      logged_q   <= logged_d;
      win_q      <= win_d;
      user_q     <= user_d;
      user_new_q <= user_new_d;
      act_q      <= act_d;
      item_q     <= item_d;
      num_q      <= num_d;
      seller_q   <= seller_d;
      amnt_q     <= amnt_d;
      chk_q      <= chk_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
    end
  end

  assign cmd_valid      = valid_q;
  assign cmd_user       = user_q;
  assign cmd_user_new   = user_new_q;
  assign cmd_act        = act_q;
  assign cmd_item       = item_q;
  assign cmd_num        = num_q;
  assign cmd_seller     = seller_q;
  assign cmd_amnt       = amnt_q;
  assign cmd_chk_seller = chk_q;
  assign proto_err      = perr_q;

endmodule
